// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display engine: mode encoding, blank
// pattern, hex-to-segment table and FSM state type.
package seg_pkg;

   localparam logic [1:0] MODE_STATIC   = 2'd0;
   localparam logic [1:0] MODE_SCROLL_L = 2'd1;
   localparam logic [1:0] MODE_BLINK    = 2'd2;
   localparam logic [1:0] MODE_SCROLL_R = 2'd3;

   // Segment bit order {g,f,e,d,c,b,a}, 1 = lit
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Entry 15 first, entry 0 last
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic [2:0] {
      StIdle,
      StStatic,
      StScrollL,
      StBlink,
      StScrollR
   } state_e;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex code to 7-segment pattern decoder (active-high).
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   // Table lookup
   always_comb begin
      seg_o = SEG_TABLE[code_i];
   end

endmodule

// File: rtl/seg_scroll_display.sv
// N-digit 7-segment display engine with static, scroll-left, scroll-right and
// blink modes. Characters and mode are captured on load; scroll/blink advance
// on an internal tick divider. Segment outputs are registered.
module seg_scroll_display
   import seg_pkg::*;
#(
   parameter int unsigned N_DIG      = 4,
   parameter int unsigned TICK_DIV   = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4*N_DIG-1:0]     chars_i,
   input  logic [1:0]             mode_i,
   input  logic                   load_i,
   output logic [7*N_DIG-1:0]     seg_o,
   output logic [((N_DIG > 1) ? $clog2(N_DIG) : 1)-1:0] offset_o,
   output logic                   tick_o
);

   localparam int unsigned OW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam int unsigned DW = $clog2(TICK_DIV);

   state_e                 state_q, state_d;
   logic [DW-1:0]          div_q, div_d;
   logic [OW-1:0]          off_q, off_d;
   logic                   phase_q, phase_d;
   logic [N_DIG-1:0][3:0]  chars_q, chars_d;
   logic [N_DIG-1:0][6:0]  seg_q, seg_d;
   logic [N_DIG-1:0][3:0]  rot_chars;
   logic [N_DIG-1:0][6:0]  dec;
   logic                   tick;
   logic                   blank;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next state: any state jumps to the mode-selected state on load
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         case (mode_i)
            MODE_STATIC:   state_d = StStatic;
            MODE_SCROLL_L: state_d = StScrollL;
            MODE_BLINK:    state_d = StBlink;
            default:       state_d = StScrollR;
         endcase
      end
   end

   // FSM outputs: divider wrap pulse and display blanking
   always_comb begin
      tick  = (state_q != StIdle) && (div_q == DW'(TICK_DIV - 1));
      blank = (state_q == StIdle) || ((state_q == StBlink) && !phase_q);
   end

   // Datapath next state; load overrides a coincident tick
   always_comb begin
      chars_d = chars_q;
      div_d   = div_q;
      off_d   = off_q;
      phase_d = phase_q;
      if (load_i) begin
         chars_d = chars_i;
         div_d   = '0;
         off_d   = '0;
         phase_d = 1'b1;
      end else if (state_q != StIdle) begin
         div_d = tick ? '0 : div_q + DW'(1);
         if (tick) begin
            case (state_q)
               StScrollL: off_d = (off_q == OW'(N_DIG - 1)) ? '0 : off_q + OW'(1);
               StScrollR: off_d = (off_q == '0) ? OW'(N_DIG - 1) : off_q - OW'(1);
               StBlink:   phase_d = ~phase_q;
               default:   ;
            endcase
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chars_q <= '0;
         div_q   <= '0;
         off_q   <= '0;
         phase_q <= 1'b1;
         seg_q   <= {N_DIG{SEG_BLANK}};
      end else begin
         chars_q <= chars_d;
         div_q   <= div_d;
         off_q   <= off_d;
         phase_q <= phase_d;
         seg_q   <= seg_d;
      end
   end

   // Rotate mux: digit k shows char[(k + offset) mod N_DIG]
   always_comb begin
      rot_chars = '0;
      for (int k = 0; k < int'(N_DIG); k++) begin
         logic [OW:0] s;
         s = {1'b0, off_q} + (OW+1)'(k);
         if (s >= (OW+1)'(N_DIG)) s = s - (OW+1)'(N_DIG);
         rot_chars[k] = chars_q[s[OW-1:0]];
      end
   end

   for (genvar g = 0; g < int'(N_DIG); g++) begin : g_dec
      hex_to_seg u_dec (
         .code_i (rot_chars[g]),
         .seg_o  (dec[g])
      );
   end

   // Output stage input: decoded pattern or blank
   always_comb begin
      seg_d = blank ? {N_DIG{SEG_BLANK}} : dec;
   end

   assign seg_o    = seg_q ^ {(7 * N_DIG){ACTIVE_LOW}};
   assign offset_o = off_q;
   assign tick_o   = tick;

endmodule
